// File: rtl/mem_arbiter.sv
// Two-port (fetch / datapath) arbiter sequencing a single-port 512x32 synchronous RAM.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN; default is fixed priority D > F.
module mem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              F_req,
  input  logic [ADDR_W-1:0] F_addr,
  output logic              F_ack,
  input  logic              D_req,
  input  logic              D_we,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_ack,
  output logic [DATA_W-1:0] Rdata,
  output logic              Ram_Read,
  output logic              Ram_Write,
  output logic [ADDR_W-1:0] Ram_Address,
  output logic [DATA_W-1:0] Ram_Mdatain,
  input  logic [DATA_W-1:0] Ram_data_output,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              gnt_d, gnt_d_nxt;
  logic              we_q, we_nxt;
  logic              prio_d;
  logic              pick_d;
  logic              rd_nxt, wr_nxt, f_ack_nxt, d_ack_nxt, busy_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] mdat_nxt, rdata_nxt;

`ifdef MEM_ARB_RR_EN
  // last_grant: 1 = D won the previous grant, 0 = F (reset value)
  logic last_grant, last_grant_nxt;

  assign prio_d = ~last_grant;

  always_comb begin
    last_grant_nxt = last_grant;
    if (state == IDLE && (F_req || D_req)) last_grant_nxt = pick_d;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) last_grant <= 1'b0;
    else         last_grant <= last_grant_nxt;
  end
`else
  assign prio_d = 1'b1;
`endif

  assign pick_d = D_req && (!F_req || prio_d);

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    gnt_d_nxt = gnt_d;
    we_nxt    = we_q;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    f_ack_nxt = 1'b0;
    d_ack_nxt = 1'b0;
    addr_nxt  = Ram_Address;
    mdat_nxt  = Ram_Mdatain;
    rdata_nxt = Rdata;
    unique case (state)
      IDLE: begin
        if (F_req || D_req) begin
          gnt_d_nxt = pick_d;
          we_nxt    = pick_d && D_we;
          addr_nxt  = pick_d ? D_addr : F_addr;
          mdat_nxt  = pick_d ? D_wdata : '0;
          rd_nxt    = !(pick_d && D_we);
          wr_nxt    = pick_d && D_we;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        // RAM output is registered, so the read word is valid during RESP
        if (!we_q) rdata_nxt = Ram_data_output;
        f_ack_nxt = !gnt_d;
        d_ack_nxt = gnt_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      gnt_d       <= 1'b0;
      we_q        <= 1'b0;
      Ram_Read    <= 1'b0;
      Ram_Write   <= 1'b0;
      Ram_Address <= '0;
      Ram_Mdatain <= '0;
      F_ack       <= 1'b0;
      D_ack       <= 1'b0;
      Rdata       <= '0;
      Busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt_d       <= gnt_d_nxt;
      we_q        <= we_nxt;
      Ram_Read    <= rd_nxt;
      Ram_Write   <= wr_nxt;
      Ram_Address <= addr_nxt;
      Ram_Mdatain <= mdat_nxt;
      F_ack       <= f_ack_nxt;
      D_ack       <= d_ack_nxt;
      Rdata       <= rdata_nxt;
      Busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard testbench for mem_arbiter: directed stimulus pushes expected acks, a monitor pops and checks them.
module tb_mem_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 9;

  logic              Clock = 1'b0;
  logic              Resetn = 1'b0;
  logic              F_req = 1'b0;
  logic [ADDR_W-1:0] F_addr = '0;
  logic              F_ack;
  logic              D_req = 1'b0;
  logic              D_we = 1'b0;
  logic [ADDR_W-1:0] D_addr = '0;
  logic [DATA_W-1:0] D_wdata = '0;
  logic              D_ack;
  logic [DATA_W-1:0] Rdata;
  logic              Ram_Read;
  logic              Ram_Write;
  logic [ADDR_W-1:0] Ram_Address;
  logic [DATA_W-1:0] Ram_Mdatain;
  logic [DATA_W-1:0] Ram_data_output;
  logic              Busy;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .F_req(F_req), .F_addr(F_addr), .F_ack(F_ack),
    .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata), .D_ack(D_ack),
    .Rdata(Rdata), .Ram_Read(Ram_Read), .Ram_Write(Ram_Write),
    .Ram_Address(Ram_Address), .Ram_Mdatain(Ram_Mdatain),
    .Ram_data_output(Ram_data_output), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  // Single-port RAM model with registered read output
  logic [DATA_W-1:0] mem [512];
  logic [DATA_W-1:0] ram_q = '0;
  assign Ram_data_output = ram_q;
  always @(posedge Clock) begin
    if (Ram_Write) mem[Ram_Address] <= Ram_Mdatain;
    if (Ram_Read)  ram_q <= mem[Ram_Address];
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int comps = 0;
  int fails = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input bit is_d, input logic [31:0] data, input int c);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.cyc  = c;
    sbq.push_back(e);
  endfunction

  task automatic wait_ack(input bit is_d);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Clock);
      seen = is_d ? D_ack : F_ack;
    end
    if (!seen) begin
      comps++;
      fails++;
      $display("FAIL ack_timeout: port %s never acked", is_d ? "D" : "F");
    end
  endtask

  // Monitor: checks every ack against the scoreboard, plus exclusivity invariants
  always @(negedge Clock) begin
    if (Resetn) begin
      chk("ack_exclusive", 64'(F_ack & D_ack), 64'd0);
      chk("rw_exclusive", 64'(Ram_Read & Ram_Write), 64'd0);
      if (F_ack || D_ack) begin
        if (sbq.size() == 0) begin
          comps++;
          fails++;
          $display("FAIL unexpected_ack: F_ack=%0b D_ack=%0b required none", F_ack, D_ack);
        end else begin
          got = sbq.pop_front();
          chk("ack_port_is_d", 64'(D_ack), 64'(got.is_d));
          chk("ack_cycle", 64'(cyc), 64'(got.cyc));
          chk("rdata", 64'(Rdata), 64'(got.data));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[9'h1FF] = 32'h12345678;
    mem[9'h010] = 32'hA0A0A0A0;
    mem[9'h020] = 32'hB0B0B0B0;
    mem[9'h0AA] = 32'h0BADF00D;
    for (int i = 1; i <= 4; i++) mem[i] = 32'hC0DE0000 + 32'(i);

    // Reset state
    repeat (2) @(negedge Clock);
    chk("reset_outputs", 64'({F_ack, D_ack, Ram_Read, Ram_Write, Busy, Ram_Address}), 64'd0);
    chk("reset_data", {Ram_Mdatain, Rdata}, 64'd0);
    Resetn = 1'b1;
    @(negedge Clock);
    chk("idle_after_reset", 64'({Busy, Ram_Read, Ram_Write, F_ack, D_ack}), 64'd0);

    // D write 0x005; Rdata must stay at its reset value
    D_req = 1; D_we = 1; D_addr = 9'h005; D_wdata = 32'hDEADBEEF;
    push(1'b1, 32'h0, cyc + 3);
    @(negedge Clock);
    chk("wr_ram_write", 64'(Ram_Write), 64'd1);
    chk("wr_ram_read", 64'(Ram_Read), 64'd0);
    chk("wr_ram_addr", 64'(Ram_Address), 64'h005);
    chk("wr_ram_mdatain", 64'(Ram_Mdatain), 64'hDEADBEEF);
    chk("wr_busy", 64'(Busy), 64'd1);
    @(negedge Clock);
    chk("wr_pulse_one_cycle", 64'(Ram_Write), 64'd0);
    wait_ack(1'b1);
    D_req = 0; D_we = 0;

    // D read 0x005
    @(negedge Clock);
    D_req = 1; D_addr = 9'h005;
    push(1'b1, 32'hDEADBEEF, cyc + 3);
    @(negedge Clock);
    chk("rd_ram_read", 64'(Ram_Read), 64'd1);
    chk("rd_ram_write", 64'(Ram_Write), 64'd0);
    @(negedge Clock);
    chk("rd_pulse_one_cycle", 64'(Ram_Read), 64'd0);
    wait_ack(1'b1);
    D_req = 0;

    // F read 0x1FF
    @(negedge Clock);
    F_req = 1; F_addr = 9'h1FF;
    push(1'b0, 32'h12345678, cyc + 3);
    @(negedge Clock);
    chk("f_ram_addr", 64'(Ram_Address), 64'h1FF);
    wait_ack(1'b0);
    F_req = 0;
    @(negedge Clock);
    chk("f_ack_width", 64'(F_ack), 64'd0);
    chk("f_rdata_held", 64'(Rdata), 64'h12345678);

    // Conflict: D served first, then F
    F_req = 1; F_addr = 9'h010;
    D_req = 1; D_we = 0; D_addr = 9'h020;
    push(1'b1, 32'hB0B0B0B0, cyc + 3);
    push(1'b0, 32'hA0A0A0A0, cyc + 6);
    wait_ack(1'b1);
    D_req = 0;
    wait_ack(1'b0);
    F_req = 0;

`ifdef MEM_ARB_RR_EN
    // Both held continuously: grants alternate D, F, D, F
    @(negedge Clock);
    F_req = 1; F_addr = 9'h1FF;
    D_req = 1; D_we = 0; D_addr = 9'h005;
    push(1'b1, 32'hDEADBEEF, cyc + 3);
    push(1'b0, 32'h12345678, cyc + 6);
    push(1'b1, 32'hDEADBEEF, cyc + 9);
    push(1'b0, 32'h12345678, cyc + 12);
    wait_ack(1'b1);
    wait_ack(1'b0);
    wait_ack(1'b1);
    wait_ack(1'b0);
    F_req = 0; D_req = 0;
`endif

    // Reset during ACCESS of a write to 0x0AA: write lost, no ack
    @(negedge Clock);
    D_req = 1; D_we = 1; D_addr = 9'h0AA; D_wdata = 32'h11111111;
    @(negedge Clock);
    chk("rst_pre_write", 64'(Ram_Write), 64'd1);
    Resetn = 0;
    #1;
    chk("rst_write_dropped", 64'(Ram_Write), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    D_req = 0; D_we = 0;
    @(negedge Clock);
    Resetn = 1;
    repeat (3) begin
      @(negedge Clock);
      chk("rst_no_ack", 64'({F_ack, D_ack}), 64'd0);
    end
    D_req = 1; D_addr = 9'h0AA;
    push(1'b1, 32'h0BADF00D, cyc + 3);
    wait_ack(1'b1);
    D_req = 0;

    // Back-to-back D reads: acks exactly 3 cycles apart
    @(negedge Clock);
    D_req = 1; D_addr = 9'h001;
    push(1'b1, 32'hC0DE0001, cyc + 3);
    for (int i = 0; i < 4; i++) begin
      wait_ack(1'b1);
      if (i < 3) begin
        D_addr = ADDR_W'(i + 2);
        push(1'b1, 32'hC0DE0000 + 32'(i + 2), cyc + 3);
      end else begin
        D_req = 0;
      end
    end

    repeat (4) @(negedge Clock);
    chk("final_idle", 64'(Busy), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
